// File: rtl/mcdf_pkg.sv
// Shared types for the MCDF channel arbiter: channel codes, default word width
// and the arbiter state encoding.
package mcdf_pkg;

    localparam int DATA_WIDE = 32;
    localparam int NUM_CH    = 3;

    typedef logic [1:0] ch_id_t;

    localparam ch_id_t CH0 = 2'b00;
    localparam ch_id_t CH1 = 2'b01;
    localparam ch_id_t CH2 = 2'b10;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Wraps CH2 back to CH0; any out-of-range code also lands on CH0.
    function automatic ch_id_t ch_next(input ch_id_t id);
        case (id)
            CH0:     return CH1;
            CH1:     return CH2;
            default: return CH0;
        endcase
    endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// Combinational request picker: the first active request found when searching
// upward (with wrap) from rr_ptr wins. With rr_ptr tied to CH0 this is fixed priority.
module mcdf_arb_pick
    import mcdf_pkg::*;
(
    input  logic [2:0] req,
    input  ch_id_t     rr_ptr,
    output ch_id_t     sel,
    output logic       any
);

    ch_id_t c0, c1, c2;

    assign c0  = (rr_ptr == 2'b11) ? CH0 : rr_ptr;
    assign c1  = ch_next(c0);
    assign c2  = ch_next(c1);
    assign any = |req;

    always_comb begin
        sel = c2;
        if (req[c0])
            sel = c0;
        else if (req[c1])
            sel = c1;
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// Three-channel burst arbiter with a registered output stage.
// Define MCDF_ARB_RR_EN for round-robin selection; default is fixed priority CH0 > CH1 > CH2.
module mcdf_arbiter #(
    parameter int DATA_WIDE = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ch0_valid,
    input  logic [DATA_WIDE-1:0] ch0_data,
    output logic                 ch0_ready,
    input  logic                 ch1_valid,
    input  logic [DATA_WIDE-1:0] ch1_data,
    output logic                 ch1_ready,
    input  logic                 ch2_valid,
    input  logic [DATA_WIDE-1:0] ch2_data,
    output logic                 ch2_ready,
    input  logic [2:0]           ch_en,
    output logic [1:0]           arb_chid,
    output logic                 arb_valid,
    output logic [DATA_WIDE-1:0] arb_data,
    input  logic                 arb_ready,
    output logic                 arb_busy
);
    import mcdf_pkg::*;

    arb_state_e           state;
    ch_id_t               grant_id;
    logic [3:0]           burst_cnt;
    ch_id_t               rr_ptr;
    ch_id_t               sel;
    logic                 any_req;
    logic [2:0]           valid_v;
    logic [2:0]           req;
    logic [2:0]           ready_v;
    logic                 load;
    logic                 xfer;
    logic                 last_word;
    logic                 grant_lost;
    logic [DATA_WIDE-1:0] data_sel;

    assign valid_v = {ch2_valid, ch1_valid, ch0_valid};
    assign req     = valid_v & ch_en;
    assign load    = !arb_valid || arb_ready;

    mcdf_arb_pick u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .sel    (sel),
        .any    (any_req)
    );

`ifdef MCDF_ARB_RR_EN
    ch_id_t rr_ptr_q;

    // Pointer advances past the winner only when a new grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_q <= CH0;
        else if (state == ARB_IDLE && any_req)
            rr_ptr_q <= ch_next(sel);
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = CH0;
`endif

    // ch_en acts combinationally so a channel disabled mid-burst stops at once.
    always_comb begin
        ready_v = 3'b000;
        if (state == ARB_GRANT && load && ch_en[grant_id])
            ready_v[grant_id] = 1'b1;
    end

    assign ch0_ready  = ready_v[0];
    assign ch1_ready  = ready_v[1];
    assign ch2_ready  = ready_v[2];
    assign xfer       = |(ready_v & valid_v);
    assign last_word  = (burst_cnt == 4'(BURST_MAX - 1));
    assign grant_lost = load && !(valid_v[grant_id] && ch_en[grant_id]);

    always_comb begin
        case (grant_id)
            CH1:     data_sel = ch1_data;
            CH2:     data_sel = ch2_data;
            default: data_sel = ch0_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            grant_id  <= CH0;
            burst_cnt <= 4'd0;
            arb_busy  <= 1'b0;
            arb_valid <= 1'b0;
            arb_data  <= '0;
            arb_chid  <= CH0;
        end else begin
            if (xfer) begin
                arb_data  <= data_sel;
                arb_chid  <= grant_id;
                arb_valid <= 1'b1;
            end else if (load) begin
                arb_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_id  <= sel;
                        burst_cnt <= 4'd0;
                        state     <= ARB_GRANT;
                        arb_busy  <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (xfer) begin
                        if (last_word) begin
                            burst_cnt <= 4'd0;
                            state     <= ARB_IDLE;
                            arb_busy  <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end else if (grant_lost) begin
                        burst_cnt <= 4'd0;
                        state     <= ARB_IDLE;
                        arb_busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ARB_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Bench for mcdf_arbiter: directed scenarios then random traffic, checked each
// cycle against a transaction-level model of the grant/burst rules.
module tb_mcdf_arbiter;

    localparam int DW = 32;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ch0_valid = 1'b0, ch1_valid = 1'b0, ch2_valid = 1'b0;
    logic [DW-1:0] ch0_data = '0, ch1_data = '0, ch2_data = '0;
    logic          ch0_ready, ch1_ready, ch2_ready;
    logic [2:0]    ch_en = 3'b111;
    logic [1:0]    arb_chid;
    logic          arb_valid;
    logic [DW-1:0] arb_data;
    logic          arb_ready = 1'b1;
    logic          arb_busy;

    mcdf_arbiter #(.DATA_WIDE(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
        .ch2_valid(ch2_valid), .ch2_data(ch2_data), .ch2_ready(ch2_ready),
        .ch_en(ch_en), .arb_chid(arb_chid), .arb_valid(arb_valid),
        .arb_data(arb_data), .arb_ready(arb_ready), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] src[3][$];
    bit            gap[3];

    // Reference model: granted channel (-1 when idle), words sent in this grant,
    // next round-robin start, and the output register contents.
    int            m_gnt, m_cnt, m_rr;
    bit            m_av;
    logic [DW-1:0] m_ad;
    logic [1:0]    m_ac;

    logic [1:0]    obs_chid[$];
    logic [DW-1:0] obs_data[$];
    int            obs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1; m_cnt = 0; m_rr = 0;
        m_av = 1'b0; m_ad = '0; m_ac = 2'd0;
    endtask

    task automatic clear_obs();
        obs_chid.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {29'b0, ch2_ready, ch1_ready, ch0_ready}, 32'd0);
        chk("rst_valid", {31'b0, arb_valid}, 32'd0);
        chk("rst_data",  arb_data, 32'd0);
        chk("rst_chid",  {30'b0, arb_chid}, 32'd0);
        chk("rst_busy",  {31'b0, arb_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // One clock: drive, check against model, advance model past the edge.
    task automatic step();
        logic [2:0]    v, rdy, en_s;
        logic [DW-1:0] d[3];
        bit            ld;
        int            xf, start, c;
        for (int n = 0; n < 3; n++) begin
            v[n] = (src[n].size() > 0) && !gap[n];
            d[n] = v[n] ? src[n][0] : $urandom;
        end
        en_s = ch_en;
        ch0_valid = v[0]; ch0_data = d[0];
        ch1_valid = v[1]; ch1_data = d[1];
        ch2_valid = v[2]; ch2_data = d[2];
        #3;
        ld  = !m_av || arb_ready;
        rdy = 3'b000;
        if (m_gnt >= 0 && ld && en_s[m_gnt]) rdy[m_gnt] = 1'b1;
        chk("ready", {29'b0, ch2_ready, ch1_ready, ch0_ready}, {29'b0, rdy});
        chk("valid", {31'b0, arb_valid}, {31'b0, m_av});
        chk("busy",  {31'b0, arb_busy}, {31'b0, (m_gnt >= 0)});
        chk("data",  arb_data, m_ad);
        chk("chid",  {30'b0, arb_chid}, {30'b0, m_ac});
        if (arb_valid && arb_ready) begin
            obs_chid.push_back(arb_chid);
            obs_data.push_back(arb_data);
            obs_cyc.push_back(cyc);
        end
        xf = -1;
        if (m_gnt >= 0 && rdy[m_gnt] && v[m_gnt]) xf = m_gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (xf >= 0) begin
            m_av = 1'b1; m_ad = d[xf]; m_ac = 2'(xf);
            void'(src[xf].pop_front());
        end else if (ld) begin
            m_av = 1'b0;
        end
        if (m_gnt < 0) begin
`ifdef MCDF_ARB_RR_EN
            start = m_rr;
`else
            start = 0;
`endif
            for (int k = 0; k < 3; k++) begin
                c = (start + k) % 3;
                if (v[c] && en_s[c]) begin
                    m_gnt = c; m_cnt = 0; m_rr = (c + 1) % 3;
                    break;
                end
            end
        end else if (xf >= 0) begin
            m_cnt++;
            if (m_cnt == BM) begin m_gnt = -1; m_cnt = 0; end
        end else if (ld && !(v[m_gnt] && en_s[m_gnt])) begin
            m_gnt = -1; m_cnt = 0;
        end
    endtask

    initial begin
        for (int n = 0; n < 3; n++) gap[n] = 1'b0;
        model_reset();
        do_reset();

        // Single-channel stream longer than one burst.
        clear_obs();
        for (int i = 0; i < 6; i++) src[0].push_back(32'hA0 + i);
        repeat (12) step();
        chk("a_count", obs_data.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("a_data", obs_data[i], 32'hA0 + i);
            chk("a_chid", {30'b0, obs_chid[i]}, 32'd0);
        end
        chk("a_back2back", obs_cyc[3] - obs_cyc[0], 32'd3);
        chk("a_idle_gap",  obs_cyc[4] - obs_cyc[3], 32'd2);

        // All channels continuously valid.
        do_reset();
        clear_obs();
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 16; i++) src[n].push_back({n[7:0], 24'h000100} + i);
        repeat (22) step();
        for (int i = 0; i < 16; i++) begin
`ifdef MCDF_ARB_RR_EN
            chk("all_chid", {30'b0, obs_chid[i]}, (i / 4) % 3);
`else
            chk("all_chid", {30'b0, obs_chid[i]}, 32'd0);
`endif
        end
        for (int n = 0; n < 3; n++) src[n].delete();
        repeat (3) step();

        // Downstream stall mid-burst.
        clear_obs();
        for (int i = 0; i < 6; i++) src[0].push_back(32'hB0 + i);
        repeat (3) step();
        arb_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_data", arb_data, 32'hB1);
            chk("stall_chid", {30'b0, arb_chid}, 32'd0);
            chk("stall_rdy0", {31'b0, ch0_ready}, 32'd0);
        end
        arb_ready = 1'b1;
        repeat (8) step();
        chk("stall_count", obs_data.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("stall_seq", obs_data[i], 32'hB0 + i);

        // CH0 disabled while CH0 and CH1 both have data.
        clear_obs();
        ch_en = 3'b110;
        for (int i = 0; i < 3; i++) begin
            src[0].push_back(32'hC0 + i);
            src[1].push_back(32'hD0 + i);
        end
        repeat (7) step();
        chk("en_count", obs_data.size(), 32'd3);
        for (int i = 0; i < 3; i++) chk("en_chid", {30'b0, obs_chid[i]}, 32'd1);
        src[0].delete();
        ch_en = 3'b111;
        repeat (3) step();

        // Reset during a CH2 burst, then re-arbitrate.
        for (int i = 0; i < 4; i++) src[2].push_back(32'hE0 + i);
        repeat (3) step();
        src[1].push_back(32'hF0);
        src[1].push_back(32'hF1);
        do_reset();
        clear_obs();
        repeat (6) step();
        chk("rst_regrant", {30'b0, obs_chid[0]}, 32'd1);
        chk("rst_regrant_d", obs_data[0], 32'hF0);
        repeat (6) step();

        // Granted channel runs dry after two words.
        do_reset();
        clear_obs();
        src[1].push_back(32'h11); src[1].push_back(32'h12);
        for (int i = 0; i < 3; i++) src[2].push_back(32'h21 + i);
        repeat (10) step();
        chk("drop_count", obs_data.size(), 32'd5);
        chk("drop_c0", {30'b0, obs_chid[1]}, 32'd1);
        chk("drop_c1", {30'b0, obs_chid[2]}, 32'd2);
        chk("drop_d1", obs_data[2], 32'h21);

        // Random traffic.
        for (int t = 0; t < 600; t++) begin
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(3) == 0 && src[n].size() < 8) src[n].push_back($urandom);
                gap[n] = ($urandom_range(4) == 0);
            end
            arb_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) ch_en = 3'($urandom_range(7));
            if (t == 300) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
